// File: rtl/output_stream_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : output_stream_buffer_pkg
// Description : Shared defaults and the count-width helper for the
//               double-banked output stream buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package output_stream_buffer_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_DEPTH      = 16;
  localparam int DEF_LANES      = 1;

  // Ceiling log2; used to size counts that must also represent DEPTH itself.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result = result + 1;
    return result;
  endfunction

endpackage : output_stream_buffer_pkg
`default_nettype wire

// File: rtl/output_stream_buffer_lane_shift_bank.sv
`default_nettype none
// ============================================================================
// Module      : lane_shift_bank
// Description : Draining word bank. Parallel load, LANES-word shift toward
//               word 0 with zero fill, and a remaining-word count.
// Revision    : 1.0 - initial release
// ============================================================================
module lane_shift_bank
  import output_stream_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int LANES      = DEF_LANES,
  parameter int CNT_W      = clog2(DEF_DEPTH + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear,
  input  logic                          load,
  input  logic [CNT_W-1:0]              load_count,
  input  logic [DEPTH*DATA_WIDTH-1:0]   load_data,
  input  logic                          shift,
  output logic [LANES*DATA_WIDTH-1:0]   head,
  output logic [CNT_W-1:0]              count
);

  localparam int               c_BANK_W    = DEPTH * DATA_WIDTH;
  localparam int               c_BEAT_W    = LANES * DATA_WIDTH;
  localparam logic [CNT_W-1:0] c_LANES_CNT = CNT_W'(LANES);

  logic [c_BANK_W-1:0] r_data;
  logic [CNT_W-1:0]    r_count;

  // Bank storage: clear beats load, load beats shift (a final-beat shift
  // and a refill on the same edge resolve to the refill).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data  <= '0;
      r_count <= '0;
    end else if (clear) begin
      r_data  <= '0;
      r_count <= '0;
    end else if (load) begin
      r_data  <= load_data;
      r_count <= load_count;
    end else if (shift && (r_count != '0)) begin
      r_data  <= r_data >> c_BEAT_W;
      r_count <= (r_count <= c_LANES_CNT) ? '0 : (r_count - c_LANES_CNT);
    end
  end

  assign head  = r_data[c_BEAT_W-1:0];
  assign count = r_count;

endmodule : lane_shift_bank
`default_nettype wire

// File: rtl/output_stream_buffer.sv
`default_nettype none
// ============================================================================
// Module      : output_stream_buffer
// Description : Two-bank output stream buffer. An active bank drains LANES
//               words per beat while a shadow bank holds the next load so
//               that back-to-back loads stream without a bubble.
// Revision    : 1.0 - initial release
// ============================================================================
module output_stream_buffer
  import output_stream_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int LANES      = DEF_LANES,
  localparam int CNT_W     = clog2(DEPTH + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          load,
  input  logic [CNT_W-1:0]              load_count,
  input  logic [DEPTH*DATA_WIDTH-1:0]   input_data,
  output logic                          load_ready,
  output logic                          load_err,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LANES*DATA_WIDTH-1:0]   out_data,
  output logic [LANES-1:0]              out_keep,
  output logic                          out_last,
  output logic                          busy
);

  localparam int               c_BANK_W    = DEPTH * DATA_WIDTH;
  localparam int               c_BEAT_W    = LANES * DATA_WIDTH;
  localparam logic [CNT_W-1:0] c_LANES_CNT = CNT_W'(LANES);
  localparam logic [CNT_W-1:0] c_DEPTH_CNT = CNT_W'(DEPTH);

  logic [c_BEAT_W-1:0] w_head;
  logic [CNT_W-1:0]    w_active_count;
  logic [c_BANK_W-1:0] r_shadow_data;
  logic [CNT_W-1:0]    r_shadow_count;
  logic [c_BANK_W-1:0] w_in_masked;
  logic [c_BANK_W-1:0] w_bank_load_data;
  logic [CNT_W-1:0]    w_bank_load_count;
  logic                w_shadow_full;
  logic                w_fire;
  logic                w_final;
  logic                w_cnt_ok;
  logic                w_load_acc;
  logic                w_to_active;
  logic                w_promote;
  logic                w_bank_load;
  logic                r_load_err;

  assign w_shadow_full = (r_shadow_count != '0);
  assign out_valid     = (w_active_count != '0);
  assign w_fire        = out_valid && out_ready;
  assign w_final       = w_fire && (w_active_count <= c_LANES_CNT);
  assign w_cnt_ok      = (load_count != '0) && (load_count <= c_DEPTH_CNT);
  assign w_load_acc    = load && !w_shadow_full && w_cnt_ok && !flush;
  assign w_to_active   = w_load_acc && (!out_valid || w_final);
  // Shadow-full implies load_ready is low, so promotion never races a load.
  assign w_promote     = w_final && w_shadow_full;
  assign w_bank_load   = w_to_active || w_promote;

  // Zero the words beyond load_count so drained lanes always read as zero.
  always_comb begin
    w_in_masked = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CNT_W'(i) < load_count)
        w_in_masked[i*DATA_WIDTH +: DATA_WIDTH] = input_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Active-bank refill source: pending shadow contents take precedence.
  always_comb begin
    w_bank_load_data  = w_in_masked;
    w_bank_load_count = load_count;
    if (w_promote) begin
      w_bank_load_data  = r_shadow_data;
      w_bank_load_count = r_shadow_count;
    end
  end

  lane_shift_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .LANES      (LANES),
    .CNT_W      (CNT_W)
  ) u_active_bank (
    .clk        (clk),
    .rst        (rst),
    .clear      (flush),
    .load       (w_bank_load),
    .load_count (w_bank_load_count),
    .load_data  (w_bank_load_data),
    .shift      (w_fire),
    .head       (w_head),
    .count      (w_active_count)
  );

  // Shadow bank: captures a load arriving mid-drain, freed on promotion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shadow_data  <= '0;
      r_shadow_count <= '0;
    end else if (flush) begin
      r_shadow_data  <= '0;
      r_shadow_count <= '0;
    end else if (w_load_acc && !w_to_active) begin
      r_shadow_data  <= w_in_masked;
      r_shadow_count <= load_count;
    end else if (w_promote) begin
      r_shadow_data  <= '0;
      r_shadow_count <= '0;
    end
  end

  // Rejected-load pulse, suppressed when the load coincides with flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_load_err <= 1'b0;
    else      r_load_err <= load && !flush && (w_shadow_full || !w_cnt_ok);
  end

  // Beat presentation: lanes at or beyond the remaining count read as zero.
  always_comb begin
    out_keep = '0;
    out_data = '0;
    for (int j = 0; j < LANES; j++) begin
      out_keep[j] = (CNT_W'(j) < w_active_count);
      if (out_keep[j])
        out_data[j*DATA_WIDTH +: DATA_WIDTH] = w_head[j*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign out_last   = out_valid && (w_active_count <= c_LANES_CNT);
  assign load_ready = !w_shadow_full;
  assign load_err   = r_load_err;
  assign busy       = out_valid || w_shadow_full;

endmodule : output_stream_buffer
`default_nettype wire

// File: tb/tb_output_stream_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_output_stream_buffer
// Description : Directed self-checking bench; one LANES=1 and one LANES=4
//               instance, DATA_WIDTH=32, DEPTH=16.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_output_stream_buffer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  // LANES=1 instance signals
  logic          a_flush = 0, a_load = 0, a_out_ready = 0;
  logic [4:0]    a_load_count = '0;
  logic [511:0]  a_input_data = '0;
  logic          a_load_ready, a_load_err, a_out_valid, a_out_last, a_busy;
  logic [31:0]   a_out_data;
  logic [0:0]    a_out_keep;

  // LANES=4 instance signals
  logic          b_flush = 0, b_load = 0, b_out_ready = 0;
  logic [4:0]    b_load_count = '0;
  logic [511:0]  b_input_data = '0;
  logic          b_load_ready, b_load_err, b_out_valid, b_out_last, b_busy;
  logic [127:0]  b_out_data;
  logic [3:0]    b_out_keep;

  always #5 clk = ~clk;

  output_stream_buffer #(.DATA_WIDTH(32), .DEPTH(16), .LANES(1)) u_dut_l1 (
    .clk(clk), .rst(rst), .flush(a_flush), .load(a_load), .load_count(a_load_count),
    .input_data(a_input_data), .load_ready(a_load_ready), .load_err(a_load_err),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_keep(a_out_keep), .out_last(a_out_last), .busy(a_busy)
  );

  output_stream_buffer #(.DATA_WIDTH(32), .DEPTH(16), .LANES(4)) u_dut_l4 (
    .clk(clk), .rst(rst), .flush(b_flush), .load(b_load), .load_count(b_load_count),
    .input_data(b_input_data), .load_ready(b_load_ready), .load_err(b_load_err),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_keep(b_out_keep), .out_last(b_out_last), .busy(b_busy)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_words(input int n, input logic [31:0] base);
    a_input_data = '0;
    for (int i = 0; i < n; i++) a_input_data[i*32 +: 32] = base + 32'(i);
  endtask

  task automatic a_idle_outputs(input string tag);
    chk({tag, "_valid"}, a_out_valid, 0);
    chk({tag, "_data"},  a_out_data,  0);
    chk({tag, "_keep"},  a_out_keep,  0);
    chk({tag, "_last"},  a_out_last,  0);
    chk({tag, "_busy"},  a_busy,      0);
    chk({tag, "_ready"}, a_load_ready, 1);
    chk({tag, "_err"},   a_load_err,  0);
  endtask

  initial begin
    // Reset state
    #1;
    a_idle_outputs("rst");
    chk("rst_b_valid", b_out_valid, 0);
    chk("rst_b_ready", b_load_ready, 1);

    // Sixteen single-word beats, load accepted on first edge after release
    rst = 1'b1;
    a_words(16, 32'h1);
    a_load_count = 5'd16; a_load = 1; a_out_ready = 1;
    tick();
    a_load = 0;
    chk("l1_first_valid", a_out_valid, 1);
    chk("l1_first_err", a_load_err, 0);
    for (int k = 1; k <= 16; k++) begin
      chk($sformatf("l1_beat%0d_data", k), a_out_data, 128'(k));
      chk($sformatf("l1_beat%0d_last", k), a_out_last, (k == 16) ? 1 : 0);
      chk($sformatf("l1_beat%0d_keep", k), a_out_keep, 1);
      tick();
    end
    chk("l1_after_valid", a_out_valid, 0);
    chk("l1_after_busy", a_busy, 0);

    // Out-of-range load counts
    a_load = 1; a_load_count = 5'd0;
    tick();
    chk("cnt0_err", a_load_err, 1);
    chk("cnt0_busy", a_busy, 0);
    a_load_count = 5'd17;
    tick();
    chk("cnt17_err", a_load_err, 1);
    chk("cnt17_busy", a_busy, 0);
    a_load = 0;
    tick();
    chk("cnt_err_clear", a_load_err, 0);

    // Shadow fill, rejected third load, stall, then bubble-free handover
    a_out_ready = 0;
    a_words(3, 32'hA1); a_load_count = 5'd3; a_load = 1;
    tick();
    chk("ld1_data", a_out_data, 32'hA1);
    chk("ld1_ready", a_load_ready, 1);
    a_words(2, 32'hB1); a_load_count = 5'd2;
    tick();
    chk("ld2_ready", a_load_ready, 0);
    chk("ld2_err", a_load_err, 0);
    chk("ld2_busy", a_busy, 1);
    a_words(1, 32'hC1); a_load_count = 5'd1;
    tick();
    chk("ld3_err", a_load_err, 1);
    chk("ld3_data_hold", a_out_data, 32'hA1);
    a_load = 0;
    tick();
    chk("stall_err_clear", a_load_err, 0);
    tick();
    chk("stall_data_hold", a_out_data, 32'hA1);
    chk("stall_last_hold", a_out_last, 0);
    chk("stall_keep_hold", a_out_keep, 1);
    a_out_ready = 1;
    chk("drain_a1", a_out_data, 32'hA1);
    tick();
    chk("drain_a2", a_out_data, 32'hA2);
    tick();
    chk("drain_a3", a_out_data, 32'hA3);
    chk("drain_a3_last", a_out_last, 1);
    tick();
    chk("drain_b1_valid", a_out_valid, 1);
    chk("drain_b1", a_out_data, 32'hB1);
    chk("drain_b1_last", a_out_last, 0);
    chk("drain_b1_ready", a_load_ready, 1);
    tick();
    chk("drain_b2", a_out_data, 32'hB2);
    chk("drain_b2_last", a_out_last, 1);
    tick();
    chk("drain_end_valid", a_out_valid, 0);
    chk("drain_end_busy", a_busy, 0);

    // Flush with a coincident load mid-drain
    a_words(4, 32'hD1); a_load_count = 5'd4; a_load = 1;
    tick();
    a_load = 0;
    chk("fl_d1", a_out_data, 32'hD1);
    tick();
    chk("fl_d2", a_out_data, 32'hD2);
    a_flush = 1; a_load = 1; a_load_count = 5'd2;
    tick();
    a_flush = 0; a_load = 0;
    a_idle_outputs("flush");
    tick();
    chk("flush_err_late", a_load_err, 0);
    chk("flush_valid_late", a_out_valid, 0);

    // Asynchronous reset mid-drain
    a_words(5, 32'hE1); a_load_count = 5'd5; a_load = 1;
    tick();
    a_load = 0;
    tick();
    chk("rst_mid_e2", a_out_data, 32'hE2);
    rst = 1'b0;
    #1;
    a_idle_outputs("rst_mid");
    rst = 1'b1;
    tick();
    chk("rst_rel_valid", a_out_valid, 0);
    chk("rst_rel_data", a_out_data, 0);

    // Four-lane beats with a partial final beat
    b_input_data = '0;
    for (int i = 0; i < 6; i++) b_input_data[i*32 +: 32] = 32'h11 + 32'(i);
    b_load_count = 5'd6; b_load = 1; b_out_ready = 1;
    tick();
    b_load = 0;
    chk("l4_b1_keep", b_out_keep, 4'b1111);
    chk("l4_b1_data", b_out_data, {32'h14, 32'h13, 32'h12, 32'h11});
    chk("l4_b1_last", b_out_last, 0);
    tick();
    chk("l4_b2_keep", b_out_keep, 4'b0011);
    chk("l4_b2_data", b_out_data, {32'h0, 32'h0, 32'h16, 32'h15});
    chk("l4_b2_last", b_out_last, 1);
    tick();
    chk("l4_end_valid", b_out_valid, 0);
    chk("l4_end_busy", b_busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_output_stream_buffer
`default_nettype wire

// File: doc/output_stream_buffer.md
OUTPUT_STREAM_BUFFER -- requirements
Module: output_stream_buffer

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the width of one word in bits.
REQ-002 Parameter DEPTH, default 16, SHALL set the words held per bank; legal range 2..256.
REQ-003 Parameter LANES, default 1, SHALL set the words per output beat; legal values are 1..DEPTH and SHALL divide DEPTH.
REQ-004 Derived constant CNT_W SHALL equal clog2(DEPTH+1).
REQ-005 clk  in  1  sole clock; all state updates on the rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 flush  in  1  synchronous clear of both banks.
REQ-008 load  in  1  request to capture input_data.
REQ-009 load_count  in  CNT_W  number of valid words in the load, legal range 1..DEPTH.
REQ-010 input_data  in  DEPTH*DATA_WIDTH  word i sits at bits [i*DATA_WIDTH +: DATA_WIDTH]; word 0 is output first.
REQ-011 load_ready  out  1  high when a load can be accepted.
REQ-012 load_err  out  1  one-cycle pulse when a load is rejected.
REQ-013 out_valid  out  1  the output beat is valid.
REQ-014 out_ready  in  1  the downstream consumer accepts the beat.
REQ-015 out_data  out  LANES*DATA_WIDTH  lane j carries word j of the active bank head.
REQ-016 out_keep  out  LANES  one bit per lane, high when that lane carries a valid word.
REQ-017 out_last  out  1  marks the final beat of a load.
REQ-018 busy  out  1  high when either bank is occupied.

Function
REQ-019 The block SHALL hold two banks: an active bank (draining) and a shadow bank (pending), each with a remaining-word count.
REQ-020 load_ready SHALL equal NOT shadow_full.
REQ-021 A load SHALL be accepted when load=1, load_ready=1 and load_count is in 1..DEPTH.
  - Destination is the active bank if the active bank is empty or completes its final beat in the same cycle.
  - Otherwise the destination is the shadow bank.
REQ-022 load_err SHALL pulse for one cycle when load=1 and either load_ready=0 or load_count is out of range; the request SHALL be dropped with no state change.
REQ-023 out_valid SHALL be high exactly while the active count is nonzero; latency from load acceptance in cycle N to out_valid is cycle N+1.
REQ-024 A beat SHALL transfer when out_valid=1 and out_ready=1.
  - The active bank shifts down by LANES words; vacated top words are zero-filled.
  - The count decrements by min(LANES, count).
REQ-025 out_data lanes at or beyond the remaining count SHALL be zero, and out_keep SHALL equal the lanes below min(LANES, count).
REQ-026 out_last SHALL be high while out_valid=1 and count<=LANES.
REQ-027 While out_valid=1 and out_ready=0, out_data, out_keep and out_last SHALL hold stable.
REQ-028 On a final-beat transfer with the shadow bank full, the shadow bank SHALL move to active on the same edge and the shadow bank SHALL be freed; out_valid SHALL stay high with no bubble.
REQ-029 On a final-beat transfer with the shadow bank empty and no accepted load, out_valid SHALL be low in the next cycle.
REQ-030 flush SHALL clear both counts and all data to zero on the next edge and SHALL take priority over load and over a beat transfer; load_err SHALL NOT pulse for a load that coincides with flush.
REQ-031 busy SHALL equal (active count != 0) OR shadow_full.
REQ-032 Asserting rst mid-drain SHALL abandon the transfer immediately, with no partial beat presented after release.

Reset
REQ-033 While rst=0, all bank words and counts SHALL be zero; out_valid, out_data, out_keep, out_last, load_err and busy SHALL be 0; load_ready SHALL be 1.
REQ-034 The first load SHALL be accepted on the first rising edge after rst deasserts.

Structure
REQ-035 The shared package SHALL hold the DATA_WIDTH, DEPTH and LANES defaults and the clog2 helper for CNT_W.
REQ-036 The active bank SHALL be a sub-module lane_shift_bank (parallel load, LANES-word shift with zero fill, count register); the shadow bank and control SHALL live in the top level.

Verification
REQ-037 LANES=1, load_count=16, words 0x1..0x10, out_ready=1 -> sixteen beats 0x1..0x10, out_last on beat 16, out_valid low in the next cycle.
REQ-038 LANES=4, load_count=6 -> beat 1 keep=4'b1111; beat 2 keep=4'b0011, lanes 2-3 zero, out_last=1.
REQ-039 A second load during a drain, then a third load -> the second is accepted to shadow with load_ready going low; the third produces a load_err pulse; the second load's data follows the first with no idle cycle.
REQ-040 out_ready held low for 5 cycles mid-drain -> out_data is unchanged and no words are lost.
REQ-041 load_count=0 or 17 with DEPTH=16 -> load_err pulses and busy stays 0.
REQ-042 Cases for flush and rst:
  - flush with a simultaneous load during a drain -> both banks empty next cycle and no load_err.
  - rst pulsed mid-drain -> all outputs at reset values.
